// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver.
// The serial line is synchronised with two flops. A falling edge on the line
// starts a frame, and the start bit is checked again at its midpoint. Each
// bit is then sampled once per bit period. Optional parity and the stop bit
// are checked. A completed frame is reported by a one-cycle rx_valid strobe,
// together with registered data and error flags.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Even-parity reduction over the collected data bits.
    function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    state_t                r_state;
    state_t                w_state_nx;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_rxs;
    logic [3:0]            r_tick_cnt;
    logic [3:0]            w_tick_nx;
    logic [2:0]            r_bit_cnt;
    logic [2:0]            w_bit_nx;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_nx;
    logic                  r_par_pend;
    logic                  w_par_pend_nx;
    logic [DATA_BITS-1:0]  r_rx_data;
    logic [DATA_BITS-1:0]  w_rx_data_nx;
    logic                  r_rx_valid;
    logic                  w_rx_valid_nx;
    logic                  r_frame_err;
    logic                  w_frame_err_nx;
    logic                  r_parity_err;
    logic                  w_parity_err_nx;
    logic                  r_busy;

    assign w_rxs = r_sync2;

    // Two-flop synchroniser on the asynchronous line; resets to idle-high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state, counter, shift-register and output-flag logic.
    always_comb begin
        w_state_nx      = r_state;
        w_tick_nx       = r_tick_cnt;
        w_bit_nx        = r_bit_cnt;
        w_shift_nx      = r_shift;
        w_par_pend_nx   = r_par_pend;
        w_rx_valid_nx   = 1'b0;
        w_rx_data_nx    = r_rx_data;
        w_frame_err_nx  = r_frame_err;
        w_parity_err_nx = r_parity_err;

        case (r_state)
            IDLE: begin
                // Start detection does not wait for an oversample tick.
                if (!w_rxs) begin
                    w_state_nx = START;
                    w_tick_nx  = 4'd0;
                end else begin
                    w_state_nx = IDLE;
                end
            end

            START: begin
                if (os_tick) begin
                    if (r_tick_cnt == 4'd7) begin
                        if (w_rxs) begin
                            // The line is high again at mid start bit, so
                            // this was a glitch. Drop it silently.
                            w_state_nx = IDLE;
                            w_tick_nx  = 4'd0;
                        end else begin
                            w_state_nx = DATA;
                            w_tick_nx  = 4'd0;
                            w_bit_nx   = 3'd0;
                        end
                    end else begin
                        w_tick_nx = r_tick_cnt + 4'd1;
                    end
                end else begin
                    w_tick_nx = r_tick_cnt;
                end
            end

            DATA: begin
                if (os_tick) begin
                    // The 4-bit counter wraps 15->0, so the next bit period
                    // starts counting on its own.
                    w_tick_nx = r_tick_cnt + 4'd1;
                    if (r_tick_cnt == 4'd15) begin
                        w_shift_nx = {w_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            if (PARITY_EN) begin
                                w_state_nx = PARITY;
                            end else begin
                                w_state_nx = STOP;
                            end
                        end else begin
                            w_bit_nx = r_bit_cnt + 3'd1;
                        end
                    end else begin
                        w_shift_nx = r_shift;
                    end
                end else begin
                    w_tick_nx = r_tick_cnt;
                end
            end

            PARITY: begin
                if (os_tick) begin
                    w_tick_nx = r_tick_cnt + 4'd1;
                    if (r_tick_cnt == 4'd15) begin
                        w_par_pend_nx = f_parity(r_shift) ^ w_rxs ^ PARITY_ODD;
                        w_state_nx    = STOP;
                    end else begin
                        w_par_pend_nx = r_par_pend;
                    end
                end else begin
                    w_tick_nx = r_tick_cnt;
                end
            end

            STOP: begin
                if (os_tick) begin
                    w_tick_nx = r_tick_cnt + 4'd1;
                    if (r_tick_cnt == 4'd15) begin
                        w_rx_valid_nx   = 1'b1;
                        w_rx_data_nx    = r_shift;
                        w_frame_err_nx  = ~w_rxs;
                        w_parity_err_nx = r_par_pend;
                        w_par_pend_nx   = 1'b0;
                        // Returning to IDLE at the stop midpoint lets the
                        // next start edge, half a bit later, be caught.
                        if (w_rxs) begin
                            w_state_nx = IDLE;
                        end else begin
                            w_state_nx = BREAK_WAIT;
                        end
                    end else begin
                        w_rx_valid_nx = 1'b0;
                    end
                end else begin
                    w_tick_nx = r_tick_cnt;
                end
            end

            BREAK_WAIT: begin
                // A held-low line reports one framing error, not a stream.
                if (w_rxs) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = BREAK_WAIT;
                end
            end

            default: begin
                w_state_nx = IDLE;
                w_tick_nx  = 4'd0;
                w_bit_nx   = 3'd0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt   <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= '0;
            r_par_pend   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_tick_cnt   <= w_tick_nx;
            r_bit_cnt    <= w_bit_nx;
            r_shift      <= w_shift_nx;
            r_par_pend   <= w_par_pend_nx;
            r_rx_data    <= w_rx_data_nx;
            r_rx_valid   <= w_rx_valid_nx;
            r_frame_err  <= w_frame_err_nx;
            r_parity_err <= w_parity_err_nx;
            r_busy       <= (w_state_nx != IDLE);
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx. There are three instances: 8N1 on line 0,
// 8E1 on line 1 and 8O1 on line 2. Each instance has its own rx line and
// its own queue of expected frames.
module tb_uart_rx;

    localparam int BIT_CLK = 64;   // 16 os_ticks at one tick per 4 clk

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       os_tick = 1'b0;
    logic [2:0] tb_rx = 3'b111;
    int         tick_div = 0;

    logic [7:0] d_n, d_e, d_o;
    logic       v_n, v_e, v_o;
    logic       fe_n, fe_e, fe_o;
    logic       pe_n, pe_e, pe_o;
    logic       b_n, b_e, b_o;
    logic       pv_n = 1'b0, pv_e = 1'b0, pv_o = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_chk  = 0;
    int n_pass = 0;

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_n (
        .clk(clk), .reset_n(reset_n), .os_tick(os_tick), .rx(tb_rx[0]),
        .rx_data(d_n), .rx_valid(v_n), .frame_err(fe_n), .parity_err(pe_n), .busy(b_n));
    uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_e (
        .clk(clk), .reset_n(reset_n), .os_tick(os_tick), .rx(tb_rx[1]),
        .rx_data(d_e), .rx_valid(v_e), .frame_err(fe_e), .parity_err(pe_e), .busy(b_e));
    uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_o (
        .clk(clk), .reset_n(reset_n), .os_tick(os_tick), .rx(tb_rx[2]),
        .rx_data(d_o), .rx_valid(v_o), .frame_err(fe_o), .parity_err(pe_o), .busy(b_o));

    always #5 clk = ~clk;

    // os_tick: one clk high out of every four, driven on the falling edge.
    always @(negedge clk) begin
        tick_div = (tick_div + 1) % 4;
        os_tick  = (tick_div == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic push(input int ln, input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.data = d; e.fe = fe; e.pe = pe;
        case (ln)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int ln, input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (ln)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_chk++;
            $display("FAIL unexpected_valid line=%0d actual data=%0h required no frame", ln, d);
        end else begin
            chk($sformatf("rx_data_l%0d", ln), 32'(d), 32'(e.data));
            chk($sformatf("frame_err_l%0d", ln), 32'(fe), 32'(e.fe));
            chk($sformatf("parity_err_l%0d", ln), 32'(pe), 32'(e.pe));
        end
    endtask

    // Monitors: pop and compare on every rx_valid, and check pulse width.
    always @(negedge clk) begin
        if (v_n) begin mon(0, d_n, fe_n, pe_n); chk("valid_pulse_l0", 32'(pv_n), 32'd0); end
        if (v_e) begin mon(1, d_e, fe_e, pe_e); chk("valid_pulse_l1", 32'(pv_e), 32'd0); end
        if (v_o) begin mon(2, d_o, fe_o, pe_o); chk("valid_pulse_l2", 32'(pv_o), 32'd0); end
        pv_n = v_n; pv_e = v_e; pv_o = v_o;
    end

    task automatic send_bit(input int ln, input logic b);
        tb_rx[ln] = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input int ln, input logic [7:0] d, input bit par_en,
                              input logic pbit, input logic stop);
        send_bit(ln, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(ln, d[i]);
        if (par_en) send_bit(ln, pbit);
        send_bit(ln, stop);
    endtask

    // Watchdog: a bounded run even if the DUT stalls.
    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(d_n), 32'd0);
        chk("rst_valid", 32'(v_n), 32'd0);
        chk("rst_fe", 32'(fe_n), 32'd0);
        chk("rst_pe", 32'(pe_n), 32'd0);
        chk("rst_busy", 32'(b_n), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy_after_reset", 32'(b_n), 32'd0);

        // 8N1 single byte.
        push(0, 8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        chk("busy_after_stop", 32'(b_n), 32'd0);
        send_bit(0, 1'b1);

        // Start glitch: low for 4 ticks, then high.
        tb_rx[0] = 1'b0;
        repeat (16) @(negedge clk);
        tb_rx[0] = 1'b1;
        chk("glitch_busy_detect", 32'(b_n), 32'd1);
        repeat (BIT_CLK) @(negedge clk);
        chk("glitch_busy_idle", 32'(b_n), 32'd0);
        push(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        send_bit(0, 1'b1);

        // Framing error, then a break of 40 bit times.
        push(0, 8'h55, 1'b1, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (40 * BIT_CLK) @(negedge clk);
        chk("break_busy", 32'(b_n), 32'd1);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        push(0, 8'h12, 1'b0, 1'b0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        send_bit(0, 1'b1);

        // Parity: even and odd instances.
        push(1, 8'h03, 1'b0, 1'b1);
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        push(1, 8'h03, 1'b0, 1'b0);
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        push(2, 8'h07, 1'b0, 1'b0);
        send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1);
        push(2, 8'h07, 1'b0, 1'b1);
        send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
        send_bit(2, 1'b1);

        // Back-to-back frames with no idle gap.
        push(0, 8'h00, 1'b0, 1'b0);
        push(0, 8'hFF, 1'b0, 1'b0);
        push(0, 8'h81, 1'b0, 1'b0);
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        send_bit(0, 1'b1);

        // Reset in the middle of the data bits of a 4th frame.
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        tb_rx[0] = 1'b0;
        repeat (BIT_CLK / 2) @(negedge clk);
        chk("midframe_busy", 32'(b_n), 32'd1);
        reset_n = 1'b0;
        tb_rx[0] = 1'b1;
        #1;
        chk("midrst_data", 32'(d_n), 32'd0);
        chk("midrst_valid", 32'(v_n), 32'd0);
        chk("midrst_fe", 32'(fe_n), 32'd0);
        chk("midrst_busy", 32'(b_n), 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("postrst_busy", 32'(b_n), 32'd0);
        push(0, 8'h5A, 1'b0, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        send_bit(0, 1'b1);

        // Every expected frame must have been presented.
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver; the consumer side of the baud generator's `oversample_tick`.
- Synchronises the asynchronous serial line, detects and validates the start bit, samples each bit at mid-bit, and checks optional parity and the stop bit.
- Presents each received byte with a one-cycle valid strobe and per-frame error flags.
- Sits between the pad-side `rx` pin and the UART core.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..8, LSB first.
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- os_tick  input  1  16x-baud one-cycle enable, driven by baud_gen `oversample_tick`.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last received data; held until the next rx_valid.
- rx_valid  output  1  one-cycle pulse when a frame completes.
- frame_err  output  1  stop bit sampled 0; valid only with rx_valid.
- parity_err  output  1  parity mismatch; valid only with rx_valid; always 0 when PARITY_EN=0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- **Reset values:** all outputs 0; state IDLE; both synchroniser flops 1 (line idle); counters 0.
- **Synchroniser:** `rx` passes through 2 flops; all logic uses the synchronised value `rxs`.
- **Counters:**
  - `tick_cnt`: 4 bits, advances only on cycles with os_tick=1.
  - `bit_cnt`: counts data bits 0..DATA_BITS-1.
  - Without os_tick, only the synchroniser and the 1-cycle rx_valid clear run.
- **IDLE:** when `rxs`=0, go to START with tick_cnt=0. Detection does not wait for os_tick.
- **START:**
  - On each os_tick, tick_cnt increments.
  - When tick_cnt==7 on an os_tick (mid start bit): if `rxs`=1, treat as a glitch and return to IDLE with no output; if `rxs`=0, go to DATA with tick_cnt=0 and bit_cnt=0.
- **DATA:**
  - On each os_tick, tick_cnt increments.
  - When tick_cnt==15 on an os_tick (one bit period after the previous sample point): shift `rxs` into the shift register at the MSB end, LSB first. After DATA_BITS shifts, the first bit received ends up at rx_data[0].
  - At bit_cnt==DATA_BITS-1 go to PARITY if PARITY_EN, else STOP; otherwise increment bit_cnt.
  - tick_cnt wraps 15→0 naturally.
- **PARITY:** sample at tick_cnt==15.
  - parity_err_next = (XOR of data bits ^ sampled bit ^ PARITY_ODD) != 0.
  - Then go to STOP.
- **STOP:** sample at tick_cnt==15.
  - Next cycle: rx_valid=1 for exactly one clk; rx_data loaded; frame_err=(sample==0); parity_err updated.
  - If the sample was 1, go to IDLE. If it was 0, go to BREAK_WAIT.
- **BREAK_WAIT:** stay until `rxs`=1, then go to IDLE. A held-low line (break) therefore yields exactly one frame_err frame, not repeated frames.
- **Back-to-back frames:** IDLE is re-entered at the stop-bit midpoint, so a start edge arriving half a bit later is caught.
- **Latency:** line edge to IDLE exit is 2 clk (synchroniser). The stop-bit sample os_tick to rx_valid is 1 clk.
- **Error flags:** frame_err and parity_err are registered with rx_valid and hold their value until the next rx_valid. Consumers qualify them with rx_valid.
- **Reset mid-frame:** immediate return to IDLE with all outputs 0; the partial frame is discarded and never reported.
- **Missing os_tick:** if os_tick is held 0, the FSM freezes in its current state with no timeout.

Test Plan:
- **8N1 single byte:** os_tick every 4 clk; send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → one rx_valid pulse, rx_data=0xA5, frame_err=0, parity_err=0, busy falls after the stop sample.
- **Start glitch:** rx low for 4 os_ticks, then high → no rx_valid, FSM back in IDLE (busy=0) after tick 7; a following 0x3C frame is received correctly.
- **Framing/break:** send 0x55 with stop=0, then hold rx low for 40 bit times → exactly one rx_valid with rx_data=0x55, frame_err=1; no further rx_valid until rx goes high and a new frame 0x12 arrives cleanly.
- **Parity:** PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 → parity_err=1. Resend with parity bit 0 → parity_err=0. PARITY_ODD=1 with 0x07 and parity bit 0 → parity_err=0.
- **Back-to-back and reset:** send 0x00, 0xFF, 0x81 with no idle gap → three rx_valid pulses in order with correct data. Then assert reset_n low in the middle of the data bits of a 4th frame → outputs 0, no rx_valid; the next full frame 0x5A is received.
